// File: rtl/addressable_latch_8_if.sv
// Bus bundle for the 8-bit addressable latch / serial-to-parallel receiver.
// master drives control, address and data; slave returns the registered outputs.
interface addressable_latch_8_if;
   logic       G_n;
   logic       CLR_n;
   logic       AUTO;
   logic       A2;
   logic       A1;
   logic       A0;
   logic       D;
   logic [7:0] Q;
   logic [7:0] WORD;
   logic       VALID;
   logic [2:0] CNT;

   modport master (
      output G_n,
      output CLR_n,
      output AUTO,
      output A2,
      output A1,
      output A0,
      output D,
      input  Q,
      input  WORD,
      input  VALID,
      input  CNT
   );

   modport slave (
      input  G_n,
      input  CLR_n,
      input  AUTO,
      input  A2,
      input  A1,
      input  A0,
      input  D,
      output Q,
      output WORD,
      output VALID,
      output CNT
   );
endinterface

// File: rtl/addressable_latch_8.sv
// 8-bit addressable latch with an auto-addressed frame receiver mode.
// Every output is a flop; next-state logic is a single combinational block.
module addressable_latch_8 (
   input logic                   clk,
   input logic                   rst,
   addressable_latch_8_if.slave  bus
);

   logic [7:0] r_q;
   logic [7:0] r_word;
   logic       r_valid;
   logic [2:0] r_cnt;

   logic [2:0] w_addr;
   logic [7:0] w_onehot;
   logic [7:0] w_dbits;
   logic [7:0] w_q_nxt;
   logic [7:0] w_word_nxt;
   logic       w_valid_nxt;
   logic [2:0] w_cnt_nxt;

   // In auto mode the frame counter replaces the external address pins.
   assign w_addr   = bus.AUTO ? r_cnt : {bus.A2, bus.A1, bus.A0};
   assign w_onehot = 8'b0000_0001 << w_addr;
   assign w_dbits  = bus.D ? w_onehot : 8'h00;

   always_comb begin
      w_q_nxt     = r_q;
      w_word_nxt  = r_word;
      w_valid_nxt = 1'b0;
      w_cnt_nxt   = r_cnt;
      if (bus.AUTO) begin
         if (!bus.CLR_n) begin
            w_q_nxt   = 8'h00;
            w_cnt_nxt = 3'd0;
         end else if (!bus.G_n) begin
            w_q_nxt   = (r_q & ~w_onehot) | w_dbits;
            w_cnt_nxt = r_cnt + 3'd1;
            // Last bit of the frame: publish the completed word with it.
            if (r_cnt == 3'd7) begin
               w_word_nxt  = (r_q & ~w_onehot) | w_dbits;
               w_valid_nxt = 1'b1;
            end
         end
      end else begin
         w_cnt_nxt = 3'd0;
         unique case ({bus.G_n, bus.CLR_n})
            2'b01:   w_q_nxt = (r_q & ~w_onehot) | w_dbits;
            2'b00:   w_q_nxt = w_dbits;
            2'b11:   w_q_nxt = r_q;
            2'b10:   w_q_nxt = 8'h00;
            default: w_q_nxt = r_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q     <= 8'h00;
         r_word  <= 8'h00;
         r_valid <= 1'b0;
         r_cnt   <= 3'd0;
      end else begin
         r_q     <= w_q_nxt;
         r_word  <= w_word_nxt;
         r_valid <= w_valid_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign bus.Q     = r_q;
   assign bus.WORD  = r_word;
   assign bus.VALID = r_valid;
   assign bus.CNT   = r_cnt;

endmodule
